// File: rtl/invntt_ctrl_if.sv
// Bus bundle between the inverse-NTT sequencer and its coefficient RAM,
// zeta ROM and butterfly datapath.
interface invntt_ctrl_if;
   // Strobe semantics: mem_we_* writes on the clock edge that ends the cycle it
   // is high. A read address yields data one cycle later. bf_ce loads the
   // operands for exactly one cycle. bf_done marks bf_out_* valid, and those
   // outputs are held until the next bf_ce. There is no back-pressure.
   logic [7:0]  mem_addr_a;
   logic [7:0]  mem_addr_b;
   logic [15:0] mem_rdata_a;
   logic [15:0] mem_rdata_b;
   logic        mem_we_a;
   logic        mem_we_b;
   logic [15:0] mem_wdata_a;
   logic [15:0] mem_wdata_b;
   logic [6:0]  zeta_idx;
   logic [15:0] zeta_rdata;
   logic        bf_ce;
   logic [15:0] bf_zeta;
   logic [15:0] bf_a;
   logic [15:0] bf_b;
   logic [15:0] bf_out_a;
   logic [15:0] bf_out_b;
   logic        bf_done;

   modport master (
      output mem_addr_a, mem_addr_b, mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b,
      output zeta_idx, bf_ce, bf_zeta, bf_a, bf_b,
      input  mem_rdata_a, mem_rdata_b, zeta_rdata, bf_out_a, bf_out_b, bf_done
   );

   modport slave (
      input  mem_addr_a, mem_addr_b, mem_we_a, mem_we_b, mem_wdata_a, mem_wdata_b,
      input  zeta_idx, bf_ce, bf_zeta, bf_a, bf_b,
      output mem_rdata_a, mem_rdata_b, zeta_rdata, bf_out_a, bf_out_b, bf_done
   );
endinterface

// File: rtl/invntt_ctrl.sv
// Kyber inverse-NTT sequencer: 7 Gentleman-Sande layers, one butterfly at a time.
// Define INVNTT_FINAL_SCALE_EN to add the final scale-by-F pass over all 256 coefficients.
module invntt_ctrl (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [3:0]           dbg_state,
   invntt_ctrl_if.master        bus
);

   localparam logic [8:0] N = 9'd256;
`ifdef INVNTT_FINAL_SCALE_EN
   localparam logic [15:0] F = 16'd1441;
`endif

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_RD         = 4'd1,
      S_LD         = 4'd2,
      S_WAIT       = 4'd3,
      S_WR         = 4'd4,
      S_FIN        = 4'd5
`ifdef INVNTT_FINAL_SCALE_EN
      ,
      S_SCALE_RD   = 4'd6,
      S_SCALE_LD   = 4'd7,
      S_SCALE_WAIT = 4'd8,
      S_SCALE_WR   = 4'd9
`endif
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] j_q, j_d;
   logic [7:0] blk_q, blk_d;
   logic [7:0] len_q, len_d;
   logic [6:0] k_q, k_d;

   logic [7:0] j_plus_len;
   logic [8:0] j_inc;
   logic [8:0] blk_end;
   logic [8:0] blk_next;

   // 9-bit sums so the len=128 block end (256) does not alias to 0.
   assign j_plus_len = j_q + len_q;
   assign j_inc      = {1'b0, j_q} + 9'd1;
   assign blk_end    = {1'b0, blk_q} + {1'b0, len_q};
   assign blk_next   = {1'b0, blk_q} + {len_q, 1'b0};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         j_q     <= 8'd0;
         blk_q   <= 8'd0;
         len_q   <= 8'd2;
         k_q     <= 7'd127;
      end else begin
         state_q <= state_d;
         j_q     <= j_d;
         blk_q   <= blk_d;
         len_q   <= len_d;
         k_q     <= k_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      j_d             = j_q;
      blk_d           = blk_q;
      len_d           = len_q;
      k_d             = k_q;
      busy            = (state_q != S_IDLE);
      done            = 1'b0;
      dbg_state       = state_q;
      bus.mem_addr_a  = 8'd0;
      bus.mem_addr_b  = 8'd0;
      bus.mem_we_a    = 1'b0;
      bus.mem_we_b    = 1'b0;
      bus.mem_wdata_a = 16'd0;
      bus.mem_wdata_b = 16'd0;
      bus.zeta_idx    = 7'd0;
      bus.bf_ce       = 1'b0;
      bus.bf_zeta     = 16'd0;
      bus.bf_a        = 16'd0;
      bus.bf_b        = 16'd0;

      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_RD;
         end
         S_RD: begin
            bus.mem_addr_a = j_q;
            bus.mem_addr_b = j_plus_len;
            bus.zeta_idx   = k_q;
            state_d        = S_LD;
         end
         S_LD: begin
            bus.bf_ce   = 1'b1;
            bus.bf_a    = bus.mem_rdata_a;
            bus.bf_b    = bus.mem_rdata_b;
            bus.bf_zeta = bus.zeta_rdata;
            state_d     = S_WAIT;
         end
         S_WAIT: begin
            if (bus.bf_done) state_d = S_WR;
         end
         S_WR: begin
            bus.mem_we_a    = 1'b1;
            bus.mem_we_b    = 1'b1;
            bus.mem_addr_a  = j_q;
            bus.mem_addr_b  = j_plus_len;
            bus.mem_wdata_a = bus.bf_out_a;
            bus.mem_wdata_b = bus.bf_out_b;
            state_d         = S_RD;
            j_d             = j_q + 8'd1;
            // Block finished: next zeta; layer finished: double len.
            if (j_inc == blk_end) begin
               k_d = k_q - 7'd1;
               if (blk_next == N) begin
                  blk_d = 8'd0;
                  j_d   = 8'd0;
                  len_d = {len_q[6:0], 1'b0};
                  if (len_q == 8'd128) begin
`ifdef INVNTT_FINAL_SCALE_EN
                     state_d = S_SCALE_RD;
`else
                     state_d = S_FIN;
`endif
                  end
               end else begin
                  blk_d = blk_next[7:0];
                  j_d   = blk_next[7:0];
               end
            end
         end
`ifdef INVNTT_FINAL_SCALE_EN
         S_SCALE_RD: begin
            bus.mem_addr_b = j_q;
            state_d        = S_SCALE_LD;
         end
         S_SCALE_LD: begin
            bus.bf_ce   = 1'b1;
            bus.bf_a    = 16'd0;
            bus.bf_b    = bus.mem_rdata_b;
            bus.bf_zeta = F;
            state_d     = S_SCALE_WAIT;
         end
         S_SCALE_WAIT: begin
            if (bus.bf_done) state_d = S_SCALE_WR;
         end
         S_SCALE_WR: begin
            bus.mem_we_b    = 1'b1;
            bus.mem_addr_b  = j_q;
            bus.mem_wdata_b = bus.bf_out_b;
            j_d             = j_q + 8'd1;
            state_d         = (j_q == 8'd255) ? S_FIN : S_SCALE_RD;
         end
`endif
         S_FIN: begin
            done    = 1'b1;
            j_d     = 8'd0;
            blk_d   = 8'd0;
            len_d   = 8'd2;
            k_d     = 7'd127;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_invntt_ctrl.sv
// Directed bench for invntt_ctrl: behavioural RAM/ROM/butterfly models and a
// software walk of the transform that produces the expected RAM image.
module tb_invntt_ctrl;

`ifdef INVNTT_FINAL_SCALE_EN
   localparam int EXP_LAT = 10369;
   localparam int EXP_WB  = 896 + 256;
`else
   localparam int EXP_LAT = 8065;
   localparam int EXP_WB  = 896;
`endif

   logic       clk;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [3:0] dbg_state;

   invntt_ctrl_if bus ();

   invntt_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .dbg_state (dbg_state),
      .bus       (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int check_n = 0;
   int pass_n  = 0;
   int fail_n  = 0;

   logic [15:0] mem [256];
   logic [15:0] exp_m [256];
   logic [15:0] exp_q [$];
   logic        load_en;
   logic [7:0]  load_addr;
   logic [15:0] load_data;
   logic [5:0]  bf_sr;

   function automatic logic [15:0] zeta_of(input logic [6:0] k);
      return {k, 9'd0} ^ (16'(k) * 16'd13 + 16'd5);
   endfunction

   // RAM with synchronous read plus a bench-only load port; zeta ROM.
   always_ff @(posedge clk) begin
      bus.mem_rdata_a <= mem[bus.mem_addr_a];
      bus.mem_rdata_b <= mem[bus.mem_addr_b];
      bus.zeta_rdata  <= zeta_of(bus.zeta_idx);
      if (load_en) begin
         mem[load_addr] <= load_data;
      end else begin
         if (bus.mem_we_a) mem[bus.mem_addr_a] <= bus.mem_wdata_a;
         if (bus.mem_we_b) mem[bus.mem_addr_b] <= bus.mem_wdata_b;
      end
   end

   // Toy butterfly: a+b, (b-a)^zeta, done 6 cycles after the load strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         bf_sr        <= 6'd0;
         bus.bf_out_a <= 16'd0;
         bus.bf_out_b <= 16'd0;
      end else begin
         bf_sr <= {bf_sr[4:0], bus.bf_ce};
         if (bus.bf_ce) begin
            bus.bf_out_a <= bus.bf_a + bus.bf_b;
            bus.bf_out_b <= (bus.bf_b - bus.bf_a) ^ bus.bf_zeta;
         end
      end
   end
   assign bus.bf_done = bf_sr[5];

   // ---------------- checking helpers ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      check_n++;
      assert (obs === exp) pass_n++;
      else begin
         fail_n++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_poly(input int mode);
      for (int i = 0; i < 256; i++) begin
         load_en   = 1'b1;
         load_addr = 8'(i);
         case (mode)
            0:       load_data = 16'd0;
            1:       load_data = (i == 0) ? 16'd1 : 16'd0;
            2:       load_data = 16'($urandom_range(0, 65535));
            default: load_data = 16'(i);
         endcase
         exp_m[i] = load_data;
         step();
      end
      load_en = 1'b0;
   endtask

   task automatic model_invntt();
      int k;
      logic [15:0] t;
      logic [15:0] u;
      logic [15:0] z;
      k = 127;
      for (int len = 2; len <= 128; len = len * 2) begin
         for (int s = 0; s < 256; s = s + 2 * len) begin
            z = zeta_of(7'(k));
            k--;
            for (int j = s; j < s + len; j++) begin
               t = exp_m[j];
               u = exp_m[j + len];
               exp_m[j]       = t + u;
               exp_m[j + len] = (u - t) ^ z;
            end
         end
      end
`ifdef INVNTT_FINAL_SCALE_EN
      for (int i = 0; i < 256; i++) exp_m[i] = exp_m[i] ^ 16'd1441;
`endif
   endtask

   task automatic check_ram();
      logic [15:0] e;
      model_invntt();
      for (int i = 0; i < 256; i++) exp_q.push_back(exp_m[i]);
      for (int i = 0; i < 256; i++) begin
         e = exp_q.pop_front();
         chk($sformatf("ram[%0d]", i), 32'(mem[i]), 32'(e));
      end
   endtask

   task automatic run(input int pulse_at, input int abort_at, input bit chk_first);
      int lat;
      int wa;
      int wb;
      int ce;
      int ovl;
      int late_we;
      bit got_done;
      lat = 0; wa = 0; wb = 0; ce = 0; ovl = 0; got_done = 1'b0;
      start = 1'b1;
      while (lat < 12000 && !got_done) begin
         step();
         lat++;
         if (lat == 1) start = 1'b0;
         if (lat == pulse_at) start = 1'b1;
         if (lat == pulse_at + 1) start = 1'b0;
         if (bus.mem_we_a) wa++;
         if (bus.mem_we_b) wb++;
         if (bus.bf_ce) ce++;
         if ((bus.mem_we_a || bus.mem_we_b) && bus.bf_ce) ovl++;
         if (chk_first) begin
            if (lat == 1) begin
               chk("rd0_busy", 32'(busy), 32'd1);
               chk("rd0_addr_a", 32'(bus.mem_addr_a), 32'd0);
               chk("rd0_addr_b", 32'(bus.mem_addr_b), 32'd2);
               chk("rd0_zeta_idx", 32'(bus.zeta_idx), 32'd127);
            end
            if (lat == 2) chk("ld0_bf_ce", 32'(bus.bf_ce), 32'd1);
            if (lat == 9) begin
               chk("wr0_we_a", 32'(bus.mem_we_a), 32'd1);
               chk("wr0_we_b", 32'(bus.mem_we_b), 32'd1);
               chk("wr0_addr_b", 32'(bus.mem_addr_b), 32'd2);
            end
            if (lat == 10) begin
               chk("rd1_addr_a", 32'(bus.mem_addr_a), 32'd1);
               chk("rd1_addr_b", 32'(bus.mem_addr_b), 32'd3);
               chk("rd1_zeta_idx", 32'(bus.zeta_idx), 32'd127);
            end
            if (lat == 19) begin
               chk("rd2_addr_a", 32'(bus.mem_addr_a), 32'd4);
               chk("rd2_addr_b", 32'(bus.mem_addr_b), 32'd6);
               chk("rd2_zeta_idx", 32'(bus.zeta_idx), 32'd126);
            end
         end
         if (lat == abort_at) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_we_a", 32'(bus.mem_we_a), 32'd0);
            chk("abort_state", 32'(dbg_state), 32'd0);
            late_we = 0;
            for (int i = 0; i < 100; i++) begin
               step();
               if (bus.mem_we_a || bus.mem_we_b) late_we++;
            end
            chk("abort_no_writes", 32'(late_we), 32'd0);
            return;
         end
         if (done) got_done = 1'b1;
      end
      chk("latency", 32'(lat), 32'(EXP_LAT));
      chk("we_a_count", 32'(wa), 32'd896);
      chk("we_b_count", 32'(wb), 32'(EXP_WB));
      chk("bf_ce_count", 32'(ce), 32'(EXP_WB));
      chk("we_ce_overlap", 32'(ovl), 32'd0);
      step();
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      load_en   = 1'b0;
      load_addr = 8'd0;
      load_data = 16'd0;
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we_a", 32'(bus.mem_we_a), 32'd0);
      chk("rst_we_b", 32'(bus.mem_we_b), 32'd0);
      chk("rst_bf_ce", 32'(bus.bf_ce), 32'd0);
      chk("rst_state", 32'(dbg_state), 32'd0);
      chk("rst_zeta_idx", 32'(bus.zeta_idx), 32'd0);

      // All-zero polynomial, with first-butterfly timing probes.
      load_poly(0);
      run(-1, 0, 1'b1);
      check_ram();

      // Unit impulse at r[0].
      load_poly(1);
      run(-1, 0, 1'b0);
      check_ram();

      // Random polynomial; a start pulse while busy must be ignored.
      load_poly(2);
      run(100, 0, 1'b0);
      check_ram();

      // Ramp polynomial, aborted by reset mid-run, then a full rerun.
      load_poly(3);
      run(-1, 4000, 1'b0);
      for (int i = 0; i < 256; i++) exp_m[i] = mem[i];
      run(-1, 0, 1'b0);
      check_ram();

      $display("%0d/%0d checks passed", pass_n, check_n);
      $finish;
   end

endmodule
